pixel_packer: RTL
=================

Name: pixel_packer

Overview:
- Sits directly downstream of the resized-crop stage.
- Consumes its 8-bit pixel stream (pixel, pixel_valid, image_done) and packs four pixels per 32-bit word into an output word FIFO.
- Presents the FIFO as a valid/ready stream with keep and last markers toward the network-input DMA.
- Drives the crop stage's stall input (its interrupt port) from FIFO occupancy, so no pixel is lost while the downstream consumer is slow.

Parameters:
- NUM_PIXELS, 784, pixels per image; 784 pixels = 196 words.
- FIFO_DEPTH, 16, output FIFO depth in 32-bit words; power of two, at least 4.
- STALL_MARGIN, 3, stall asserts when free FIFO entries are at most this value.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_i  in  8  pixel from the crop stage
- pixel_valid  in  1  pixel_i valid this cycle
- image_done  in  1  single-cycle pulse, crop stage finished an image
- stall  out  1  connects to the crop stage interrupt; high means stop sending pixels
- m_data  out  32  packed word; first pixel of each group in [7:0], fourth in [31:24]
- m_keep  out  4  per-byte valid; bit i covers m_data[8i+7:8i]
- m_last  out  1  final word of an image
- m_valid  out  1  head FIFO word is valid
- m_ready  in  1  consumer accepts the word when m_valid and m_ready are both high
- overflow  out  1  sticky; a pixel arrived while the FIFO was full
- short_frame  out  1  sticky; image_done arrived before NUM_PIXELS pixels
- clear_flags  in  1  clears overflow and short_frame

Behaviour:
- Reset (synchronous, active-high) clears:
  - the FIFO (occupancy 0) and the pack register;
  - lane counter (0..3) and pixel counter (0..NUM_PIXELS-1);
  - all outputs: m_valid=0, m_data=0, m_keep=0, m_last=0, stall=0, overflow=0, short_frame=0.
- Reset mid-image discards all buffered and partial data. No word is emitted for it.
- Packing:
  - Each accepted pixel is written into lane = lane counter; the lane counter then increments mod 4 and the pixel counter increments.
  - A word is pushed in the same clock edge as the pixel that completes it. Completion means lane 3, or pixel counter = NUM_PIXELS-1.
  - On the final pixel: m_last=1 and the pixel counter wraps to 0. Unused upper lanes are zero with keep=0.
  - With NUM_PIXELS=784, every word has keep=4'b1111.
- At most one FIFO push per cycle.
- Short frame: image_done arrives with pixel counter != 0.
  - If lane > 0, or the same-cycle pixel completes a word: push the partial or complete word with m_last=1 and keep matching the filled lanes.
  - If lane == 0 and no same-cycle pixel: push an empty word (data 0, keep 0000, last 1).
  - In all cases: set short_frame, reset both counters.
- image_done with pixel counter == 0 (normal end of image, already terminated): ignored.
- Pixel and image_done in the same cycle: the pixel is packed first, then the short-frame rule is evaluated on the result.
- FIFO:
  - Register-based, first-word fall-through. m_data/m_keep/m_last/m_valid come straight from the head entry.
  - Latency: word pushed at edge k is visible with m_valid=1 in cycle k+1.
  - Pop on m_valid & m_ready. Pushing and popping in the same cycle is legal at any occupancy, including full.
  - Output fields hold stable while m_valid=1 and m_ready=0.
- Full: a push when occupancy = FIFO_DEPTH and there is no same-cycle pop:
  - the word is dropped;
  - overflow is set;
  - counters still advance, so image alignment is preserved.
- Stall: registered. stall(t+1) = (FIFO_DEPTH - occupancy(t)) <= STALL_MARGIN.
  - The crop stage can still deliver pixels for up to 2 cycles after stall rises; the margin absorbs these.
  - Pixels arriving while stall=1 are accepted normally.
- Flags: clear_flags clears both flags. A set event in the same cycle as clear_flags wins (flag stays 1).
- Pointer and occupancy arithmetic: log2(FIFO_DEPTH)+1 bits, wrapping naturally. The pixel counter is 10 bits wide.

Test Plan:
- Full image, m_ready=1:
  - stimulus: 784 consecutive pixels, value = index mod 256;
  - response: 196 words; word 0 = 32'h03020100; word 195 = 32'h0F0E0D0C with m_last=1; keep=1111 on all words; stall never asserted; no flags set.
- Backpressure:
  - stimulus: m_ready=0; push pixels with the crop-stage interrupt loop closed;
  - response: stall rises the cycle after occupancy reaches 13; m_valid stays 1 with stable data; no overflow. Release m_ready: 196 words arrive in order with no drops or duplicates.
- Overflow:
  - stimulus: m_ready=0, stall ignored, 72 pixels;
  - response: 16 words stored, overflow=1. Then clear_flags: overflow=0.
- Short frame:
  - 10 pixels then image_done: words hold pixels 0-3, 4-7, then 8-9 with keep=0011 and last=1; short_frame=1.
  - 8 pixels then image_done: an empty last word with keep=0000 follows.
- Simultaneous pixel 4 (lane 3) and image_done: a single word with keep=1111 and last=1.
- Reset:
  - mid-image: reset after 100 pixels, then a full image → exactly 196 words, first = pixels 0-3.
  - simultaneous push/pop at full occupancy: occupancy stays 16, no overflow.

Source files
------------

// File: rtl/pixel_packer.sv
// Packs the crop stage's 8-bit pixel stream into 32-bit words held in a
// register FIFO, presented as a valid/ready stream; stalls the crop stage from FIFO occupancy.
module pixel_packer #(
  parameter int NUM_PIXELS   = 784,
  parameter int FIFO_DEPTH   = 16,
  parameter int STALL_MARGIN = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pixel_i,
  input  logic        pixel_valid,
  input  logic        image_done,
  output logic        stall,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        overflow,
  output logic        short_frame,
  input  logic        clear_flags
);

  localparam int PW     = $clog2(FIFO_DEPTH) + 1;
  localparam int AW     = PW - 1;
  localparam int WORD_W = 37;

  localparam logic [9:0]    LAST_IDX = 10'(NUM_PIXELS - 1);
  localparam logic [PW-1:0] DEPTH_W  = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] MARGIN_W = PW'(STALL_MARGIN);
  localparam logic [PW-1:0] ONE_W    = PW'(1);

  typedef struct packed {
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } word_t;

  function automatic logic [3:0] keep_mask(input logic [2:0] fill);
    case (fill)
      3'd0:    keep_mask = 4'b0000;
      3'd1:    keep_mask = 4'b0001;
      3'd2:    keep_mask = 4'b0011;
      3'd3:    keep_mask = 4'b0111;
      default: keep_mask = 4'b1111;
    endcase
  endfunction

  logic [1:0]    lane_r;
  logic [9:0]    pix_cnt_r;
  logic [23:0]   pack_r;
  word_t         mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic          stall_r;
  logic          overflow_r;
  logic          short_frame_r;

  logic [31:0]   cur_data_s;
  logic [2:0]    fill_s;
  logic [1:0]    lane_nxt_s;
  logic [9:0]    cnt_nxt_s;
  logic [23:0]   pack_nxt_s;
  logic          push_s;
  logic          push_last_s;
  logic          short_set_s;
  word_t         push_word_s;
  word_t         head_s;
  logic [PW-1:0] occ_s;
  logic          full_s;
  logic          valid_s;
  logic          pop_s;
  logic          wr_en_s;
  logic          ovf_set_s;
  logic          stall_nxt_s;

  // Pack the incoming pixel, then apply the end-of-image rule to the result.
  always_comb begin
    cur_data_s  = {8'h00, pack_r};
    fill_s      = {1'b0, lane_r};
    lane_nxt_s  = lane_r;
    cnt_nxt_s   = pix_cnt_r;
    push_s      = 1'b0;
    push_last_s = 1'b0;
    short_set_s = 1'b0;
    if (pixel_valid) begin
      case (lane_r)
        2'd0:    cur_data_s[7:0]   = pixel_i;
        2'd1:    cur_data_s[15:8]  = pixel_i;
        2'd2:    cur_data_s[23:16] = pixel_i;
        2'd3:    cur_data_s[31:24] = pixel_i;
        default: cur_data_s[7:0]   = pixel_i;
      endcase
      fill_s = {1'b0, lane_r} + 3'd1;
      if (pix_cnt_r == LAST_IDX) begin
        push_s      = 1'b1;
        push_last_s = 1'b1;
        lane_nxt_s  = 2'd0;
        cnt_nxt_s   = 10'd0;
      end else if (lane_r == 2'd3) begin
        push_s     = 1'b1;
        lane_nxt_s = 2'd0;
        cnt_nxt_s  = pix_cnt_r + 10'd1;
      end else begin
        lane_nxt_s = lane_r + 2'd1;
        cnt_nxt_s  = pix_cnt_r + 10'd1;
      end
    end else begin
      fill_s = {1'b0, lane_r};
    end
    // A premature image end flushes whatever is held (possibly an empty word).
    if (image_done && (cnt_nxt_s != 10'd0)) begin
      push_s      = 1'b1;
      push_last_s = 1'b1;
      short_set_s = 1'b1;
      lane_nxt_s  = 2'd0;
      cnt_nxt_s   = 10'd0;
    end else begin
      short_set_s = 1'b0;
    end
    if (push_s) begin
      pack_nxt_s = 24'h000000;
    end else begin
      pack_nxt_s = cur_data_s[23:0];
    end
    push_word_s.last = push_last_s;
    push_word_s.keep = keep_mask(fill_s);
    push_word_s.data = cur_data_s;
  end

  // FIFO status and push/pop qualification.
  always_comb begin
    occ_s       = wr_ptr_r - rd_ptr_r;
    valid_s     = (occ_s != {PW{1'b0}});
    full_s      = (occ_s == DEPTH_W);
    pop_s       = valid_s & m_ready;
    wr_en_s     = push_s & (~full_s | pop_s);
    ovf_set_s   = push_s & full_s & ~pop_s;
    stall_nxt_s = ((DEPTH_W - occ_s) <= MARGIN_W);
  end

  // Lane, pixel counter and partial-word register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_r    <= 2'd0;
      pix_cnt_r <= 10'd0;
      pack_r    <= 24'h000000;
    end else begin
      lane_r    <= lane_nxt_s;
      pix_cnt_r <= cnt_nxt_s;
      pack_r    <= pack_nxt_s;
    end
  end

  // Word storage and pointers; a full-FIFO write lands in the slot being popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {WORD_W{1'b0}};
      end
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_word_s;
        wr_ptr_r                <= wr_ptr_r + ONE_W;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_W;
      end
    end
  end

  // Stall and sticky flags; a set event beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_r       <= 1'b0;
      overflow_r    <= 1'b0;
      short_frame_r <= 1'b0;
    end else begin
      stall_r <= stall_nxt_s;
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clear_flags) begin
        overflow_r <= 1'b0;
      end
      if (short_set_s) begin
        short_frame_r <= 1'b1;
      end else if (clear_flags) begin
        short_frame_r <= 1'b0;
      end
    end
  end

  assign head_s      = mem_r[rd_ptr_r[AW-1:0]];
  assign m_data      = head_s.data;
  assign m_keep      = head_s.keep;
  assign m_last      = head_s.last;
  assign m_valid     = valid_s;
  assign stall       = stall_r;
  assign overflow    = overflow_r;
  assign short_frame = short_frame_r;

endmodule
